int_handler_fsm: RTL
====================

Name: int_handler_fsm

Overview:
- Sequential interrupt-handler controller: state register, timeout counter and registered Moore outputs.
- Sits directly upstream of the interrupt-handler combinational next-state/output slice.
- Supplies registered state and the control signals: cc_mux, uscite, enable_count, ackout.
- Lets the combinational benchmark be closed into a full clocked design for equivalence and CGP-evolution runs.

Parameters:
- TIMEOUT, 4, WAIT cycles without eql before forcing an interrupt; legal range 1..2**CNT_W.
- CNT_W, 4, width of the wait counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- eql  input  1  compare-equal request from the datapath.
- cont_eql  input  1  continue/hold request.
- cc_mux  output  2  mux select to the datapath.
- uscite  output  2  status code.
- enable_count  output  1  datapath counter enable.
- ackout  output  1  acknowledge.

Behaviour:
- Clocking and reset:
  - One clock, `clock`.
  - `reset` is asynchronous and active-high; it forces state INIT and wait counter 0 immediately, without waiting for a clock edge.
- Outputs:
  - All outputs are pure Moore functions of the state register, so each output reflects the state with 0-cycle decode delay.
  - Reset values: cc_mux=01, uscite=00, enable_count=1, ackout=0.
- State encoding (3 bits) and outputs as cc_mux, uscite, enable_count, ackout:
  - INIT=0: 01, 00, 1, 0
  - WAIT=1: 01, 00, 1, 0
  - ENIN=2: 11, 00, 0, 1
  - ENIN_W=3: 11, 01, 0, 1
  - INTR=4: 10, 01, 0, 0
  - INTR_1=5: 10, 10, 0, 0
  - INTR_W=6: 10, 11, 0, 1
- Transitions, evaluated on each rising edge:
  - INIT -> WAIT, unconditional.
  - WAIT:
    - eql=1 -> ENIN.
    - else cnt==TIMEOUT-1 -> INTR.
    - else stay in WAIT and cnt++.
  - ENIN: eql=1 -> ENIN_W; else -> INTR.
  - ENIN_W: cont_eql=1 -> stay; else -> WAIT.
  - INTR: cont_eql=1 -> INTR_1; else -> INTR_W.
  - INTR_1 -> INTR_W, unconditional.
  - INTR_W: eql=1 -> WAIT; else stay.
  - Illegal code 7 -> INIT on the next edge, with outputs decoded as INIT.
- Wait counter:
  - Cleared to 0 on every edge where the current state is not WAIT, so each entry into WAIT starts a fresh TIMEOUT window.
  - Counts only in WAIT; never wraps, because the FSM leaves WAIT at TIMEOUT-1.
  - TIMEOUT=1: WAIT lasts exactly one cycle when eql=0.
- Priorities:
  - eql and timeout in the same WAIT cycle: eql wins, next state ENIN.
  - eql and cont_eql are evaluated only in the states listed above; elsewhere they are ignored.
- Reset mid-operation: from any state, outputs return to INIT values asynchronously. The first edge after reset release moves to WAIT.

Optional Feature:
- Macro: INT_HANDLER_OBS_EN.
- Defined:
  - Adds output `state_o[2:0]`, a direct copy of the state register.
  - Adds output `intr_cnt[7:0]`, which counts entries into INTR (WAIT->INTR or ENIN->INTR).
  - intr_cnt saturates at 255, resets asynchronously to 0, and is not cleared by other states.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package int_handler_pkg:
  - State type and its 3-bit encodings INIT..INTR_W.
  - Output constants CC_MUX_IDLE=01, CC_MUX_EN=11, CC_MUX_INT=10.
  - USCITE_* codes.
  - STATE_W=3.
- One sub-module: int_timeout_cnt.
  - Parameters CNT_W and TIMEOUT.
  - Inputs `clock`, `reset`, `run` (high in WAIT), `clr`.
  - Output `tmo`, high when cnt==TIMEOUT-1.

Test Plan (TIMEOUT=4):
1. Reset pulse, eql=0 and cont_eql=0 held -> INIT for 1 cycle, WAIT for exactly 4 cycles (enable_count=1), then INTR (cc_mux=10, uscite=01, ackout=0), then INTR_W (uscite=11, ackout=1) held.
2. eql=1 in the first WAIT cycle -> ENIN (cc_mux=11, ackout=1, enable_count=0). eql=1 again -> ENIN_W (uscite=01). cont_eql=1 for 3 cycles holds ENIN_W; cont_eql=0 -> WAIT (cc_mux=01).
3. eql=1 in the same cycle the counter reaches 3 -> next state ENIN, not INTR.
4. Assert reset asynchronously mid-ENIN_W, between edges -> outputs 01/00/1/0 before the next edge. Release -> WAIT on the first edge.
5. From ENIN with eql=0 -> INTR. cont_eql=1 -> INTR_1 (uscite=10) -> INTR_W. eql=1 -> WAIT, which lasts a full 4 cycles (counter restarted at 0).
6. With INT_HANDLER_OBS_EN defined:
   - 3 timeout-driven INTR entries -> intr_cnt=3, state_o tracks the encodings.
   - 300 entries -> intr_cnt=255.

Source files
------------

// File: rtl/int_handler_pkg.sv
// Shared state encodings, output codes and the Moore output decode for the interrupt-handler FSM.
package int_handler_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_INIT   = 3'd0;
    localparam logic [STATE_W-1:0] S_WAIT   = 3'd1;
    localparam logic [STATE_W-1:0] S_ENIN   = 3'd2;
    localparam logic [STATE_W-1:0] S_ENIN_W = 3'd3;
    localparam logic [STATE_W-1:0] S_INTR   = 3'd4;
    localparam logic [STATE_W-1:0] S_INTR_1 = 3'd5;
    localparam logic [STATE_W-1:0] S_INTR_W = 3'd6;

    localparam logic [1:0] CC_MUX_IDLE = 2'b01;
    localparam logic [1:0] CC_MUX_EN   = 2'b11;
    localparam logic [1:0] CC_MUX_INT  = 2'b10;

    localparam logic [1:0] USCITE_NONE = 2'b00;
    localparam logic [1:0] USCITE_HOLD = 2'b01;
    localparam logic [1:0] USCITE_INT1 = 2'b10;
    localparam logic [1:0] USCITE_INTW = 2'b11;

    typedef struct packed {
        logic [1:0] cc_mux;
        logic [1:0] uscite;
        logic       enable_count;
        logic       ackout;
    } ctrl_t;

    // Unused code 7 decodes like INIT so the outputs stay sane until the FSM recovers.
    function automatic ctrl_t decode_ctrl(input logic [STATE_W-1:0] s);
        ctrl_t c;
        c = '{CC_MUX_IDLE, USCITE_NONE, 1'b1, 1'b0};
        case (s)
            S_ENIN:   c = '{CC_MUX_EN,  USCITE_NONE, 1'b0, 1'b1};
            S_ENIN_W: c = '{CC_MUX_EN,  USCITE_HOLD, 1'b0, 1'b1};
            S_INTR:   c = '{CC_MUX_INT, USCITE_HOLD, 1'b0, 1'b0};
            S_INTR_1: c = '{CC_MUX_INT, USCITE_INT1, 1'b0, 1'b0};
            S_INTR_W: c = '{CC_MUX_INT, USCITE_INTW, 1'b0, 1'b1};
            default:  c = '{CC_MUX_IDLE, USCITE_NONE, 1'b1, 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/int_handler_fsm_if.sv
// Request/control bundle between the datapath and the interrupt-handler FSM.
// INT_HANDLER_OBS_EN adds the state_o / intr_cnt observation signals.
interface int_handler_fsm_if;
    import int_handler_pkg::*;

    logic             eql;
    logic             cont_eql;
    logic [1:0]       cc_mux;
    logic [1:0]       uscite;
    logic             enable_count;
    logic             ackout;
`ifdef INT_HANDLER_OBS_EN
    logic [STATE_W-1:0] state_o;
    logic [7:0]         intr_cnt;

    modport master (output eql, cont_eql,
                    input  cc_mux, uscite, enable_count, ackout, state_o, intr_cnt);
    modport slave  (input  eql, cont_eql,
                    output cc_mux, uscite, enable_count, ackout, state_o, intr_cnt);
`else
    modport master (output eql, cont_eql,
                    input  cc_mux, uscite, enable_count, ackout);
    modport slave  (input  eql, cont_eql,
                    output cc_mux, uscite, enable_count, ackout);
`endif

endinterface

// File: rtl/int_timeout_cnt.sv
// WAIT-window counter: clears whenever clr is high, counts while run is high, flags cnt==TIMEOUT-1.
// Holds at the terminal value so it can never wrap, even for TIMEOUT=2**CNT_W.
module int_timeout_cnt #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tmo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !tmo) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tmo = (cnt == LAST);

endmodule

// File: rtl/int_handler_fsm.sv
// Interrupt-handler controller: state register, WAIT timeout and Moore decode of cc_mux/uscite/enable_count/ackout.
// INT_HANDLER_OBS_EN exposes the state register and a saturating count of INTR entries.
module int_handler_fsm
    import int_handler_pkg::*;
#(
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    int_handler_fsm_if.slave   bus
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               in_wait;
    logic               tmo;
    ctrl_t              ctrl;

    assign in_wait = (state == S_WAIT);

    int_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clock (clock),
        .reset (reset),
        .run   (in_wait),
        .clr   (!in_wait),
        .tmo   (tmo)
    );

    always_comb begin
        state_nxt = S_INIT;
        case (state)
            S_INIT:   state_nxt = S_WAIT;
            // eql beats a simultaneous timeout.
            S_WAIT:   state_nxt = bus.eql ? S_ENIN : (tmo ? S_INTR : S_WAIT);
            S_ENIN:   state_nxt = bus.eql ? S_ENIN_W : S_INTR;
            S_ENIN_W: state_nxt = bus.cont_eql ? S_ENIN_W : S_WAIT;
            S_INTR:   state_nxt = bus.cont_eql ? S_INTR_1 : S_INTR_W;
            S_INTR_1: state_nxt = S_INTR_W;
            S_INTR_W: state_nxt = bus.eql ? S_WAIT : S_INTR_W;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    assign ctrl             = decode_ctrl(state);
    assign bus.cc_mux       = ctrl.cc_mux;
    assign bus.uscite       = ctrl.uscite;
    assign bus.enable_count = ctrl.enable_count;
    assign bus.ackout       = ctrl.ackout;

`ifdef INT_HANDLER_OBS_EN
    logic [7:0] intr_cnt;
    logic       intr_entry;

    assign intr_entry = (state_nxt == S_INTR) && (state == S_WAIT || state == S_ENIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            intr_cnt <= 8'd0;
        end else if (intr_entry && intr_cnt != 8'hFF) begin
            intr_cnt <= intr_cnt + 8'd1;
        end
    end

    assign bus.state_o  = state;
    assign bus.intr_cnt = intr_cnt;
`endif

endmodule
